// File: rtl/tmp_decimator_if.sv
// Decision-in / code-out bundle for the thermometer-pump decimator.
// master drives decisions and acceptance; slave is the decimator.
interface tmp_decimator_if #(
  parameter int unsigned CW = 9
) ();
  logic          dec_stb;
  logic          dec_bit;
  logic [CW-1:0] code;
  logic          code_valid;
  logic          code_ready;

  modport master (
    output dec_stb,
    output dec_bit,
    output code_ready,
    input  code,
    input  code_valid
  );

  modport slave (
    input  dec_stb,
    input  dec_bit,
    input  code_ready,
    output code,
    output code_valid
  );
endinterface

// File: rtl/tmp_decimator.sv
// Counts source-pump decisions over a fixed window of comparator strobes and
// hands the total out on a valid/ready handshake, after an initial settle phase.
module tmp_decimator #(
  parameter int unsigned NSAMP   = 256,
  parameter int unsigned NSETTLE = 8,
  parameter int unsigned CW      = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  tmp_decimator_if.slave  bus,
  output logic            busy,
  output logic            overrun
);

  localparam int unsigned SW = (NSETTLE > 1) ? $clog2(NSETTLE) : 1;
  localparam int unsigned NW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam logic [SW-1:0] SettleLast = SW'(NSETTLE - 1);
  localparam logic [NW-1:0] SampLast   = NW'(NSAMP - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StAccum, StHold} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [NW-1:0] samp_q, samp_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] code_q, code_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          busy_q;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    samp_d    = samp_q;
    ones_d    = ones_q;
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d   = StSettle;
          settle_d  = '0;
          samp_d    = '0;
          ones_d    = '0;
          overrun_d = 1'b0;
        end
      end

      StSettle: begin
        if (!en) begin
          state_d  = StIdle;
          settle_d = '0;
        end else if (bus.dec_stb) begin
          if (settle_q == SettleLast) begin
            state_d  = StAccum;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end

      StAccum: begin
        if (!en) begin
          state_d = StIdle;
          samp_d  = '0;
          ones_d  = '0;
        end else if (bus.dec_stb) begin
          if (samp_q == SampLast) begin
            // Final strobe: its own bit is folded straight into the code.
            code_d  = ones_q + CW'(bus.dec_bit);
            valid_d = 1'b1;
            state_d = StHold;
            samp_d  = '0;
            ones_d  = '0;
          end else begin
            samp_d = samp_q + 1'b1;
            ones_d = ones_q + CW'(bus.dec_bit);
          end
        end
      end

      StHold: begin
        if (bus.code_ready) begin
          valid_d = 1'b0;
          if (en) begin
            // A strobe on the handshake edge opens the next window.
            state_d = StAccum;
            samp_d  = bus.dec_stb ? NW'(1) : '0;
            ones_d  = (bus.dec_stb && bus.dec_bit) ? CW'(1) : '0;
          end else begin
            state_d = StIdle;
            samp_d  = '0;
            ones_d  = '0;
          end
        end else if (bus.dec_stb) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      samp_q    <= '0;
      ones_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      samp_q    <= samp_d;
      ones_q    <= ones_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_tmp_decimator.sv
// Directed bench for tmp_decimator with NSAMP=8, NSETTLE=2, CW=4.
module tb_tmp_decimator;

  logic clk;
  logic reset;
  logic en;
  logic busy;
  logic overrun;

  int unsigned checks;
  int unsigned errors;

  tmp_decimator_if #(.CW(4)) bus ();

  tmp_decimator #(
    .NSAMP  (8),
    .NSETTLE(2),
    .CW     (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .bus    (bus),
    .busy   (busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    bus.dec_stb = 1'b1;
    bus.dec_bit = b;
    tick();
    bus.dec_stb = 1'b0;
    bus.dec_bit = 1'b0;
  endtask

  // Eight accumulation strobes, MSB first; checks one-edge latency and the code.
  task automatic window(input string tag, input logic [7:0] bits, input int unsigned exp);
    for (int i = 7; i >= 1; i--) strobe(bits[i]);
    check({tag, "_valid_early"}, 32'(bus.code_valid), 32'd0);
    strobe(bits[0]);
    check({tag, "_valid"}, 32'(bus.code_valid), 32'd1);
    check({tag, "_code"}, 32'(bus.code), exp);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic handshake(input logic en_val, input logic with_stb, input logic b);
    en            = en_val;
    bus.code_ready = 1'b1;
    bus.dec_stb    = with_stb;
    bus.dec_bit    = b;
    tick();
    bus.code_ready = 1'b0;
    bus.dec_stb    = 1'b0;
    bus.dec_bit    = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    en             = 1'b0;
    bus.dec_stb    = 1'b0;
    bus.dec_bit    = 1'b0;
    bus.code_ready = 1'b0;

    #3;
    check("rst_code", 32'(bus.code), 32'd0);
    check("rst_valid", 32'(bus.code_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // First window after settle.
    en = 1'b1;
    tick();
    check("settle_busy", 32'(busy), 32'd1);
    strobe(1'b1);
    strobe(1'b1);
    window("w1", 8'b1011_0010, 4);
    check("w1_overrun", 32'(overrun), 32'd0);

    // Strobe coincident with handshake is the first sample of the next window.
    handshake(1'b1, 1'b1, 1'b1);
    check("hs1_valid", 32'(bus.code_valid), 32'd0);
    for (int i = 0; i < 6; i++) strobe(1'b0);
    check("w2_valid_early", 32'(bus.code_valid), 32'd0);
    strobe(1'b0);
    check("w2_valid", 32'(bus.code_valid), 32'd1);
    check("w2_code", 32'(bus.code), 32'd1);
    check("w2_overrun", 32'(overrun), 32'd0);

    // All-ones window must reach NSAMP without wrapping.
    handshake(1'b1, 1'b0, 1'b0);
    window("w3", 8'hFF, 8);

    // Dropped decision in HOLD sets overrun, code held.
    strobe(1'b1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_code", 32'(bus.code), 32'd8);
    check("ovr_valid", 32'(bus.code_valid), 32'd1);
    handshake(1'b1, 1'b0, 1'b0);
    check("hs3_valid", 32'(bus.code_valid), 32'd0);
    window("w4", 8'h00, 0);
    check("w4_overrun", 32'(overrun), 32'd1);

    // Window 5 gives a nonzero code so the abort below shows it is held.
    handshake(1'b1, 1'b0, 1'b0);
    window("w5", 8'b0110_0001, 3);

    // Handshake with en low returns to IDLE.
    handshake(1'b0, 1'b0, 1'b0);
    check("hs_idle_busy", 32'(busy), 32'd0);
    check("hs_idle_valid", 32'(bus.code_valid), 32'd0);
    en = 1'b1;
    tick();
    check("reen_overrun", 32'(overrun), 32'd0);
    strobe(1'b1);
    strobe(1'b1);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    en = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(bus.code_valid), 32'd0);
    check("abort_code", 32'(bus.code), 32'd3);

    // Re-enable must settle again: two settle strobes swallowed.
    en = 1'b1;
    tick();
    strobe(1'b1);
    strobe(1'b1);
    window("w6", 8'b1100_0000, 2);
    handshake(1'b0, 1'b0, 1'b0);
    check("idle_code_hold", 32'(bus.code), 32'd2);

    // Asynchronous reset mid-ACCUM.
    en = 1'b1;
    tick();
    strobe(1'b1);
    strobe(1'b1);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_code", 32'(bus.code), 32'd0);
    check("arst_valid", 32'(bus.code_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1'b1);
    check("post_rst_valid", 32'(bus.code_valid), 32'd0);
    en = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmp_decimator.md
TMP_DECIMATOR -- requirements
Module: tmp_decimator

Interface
REQ-001 Parameter NSAMP, default 256: comparator decisions accumulated per conversion.
REQ-002 Parameter NSETTLE, default 8: decisions discarded after enable, before the first conversion.
REQ-003 Parameter CW, default 9: code width; SHALL satisfy 2^CW > NSAMP.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  conversion enable; high once the front-end bias setup is finished.
REQ-007 dec_stb  input  1  one-cycle strobe, one per comparator pump decision.
REQ-008 dec_bit  input  1  decision qualified by dec_stb; 1 = source pump, 0 = sink pump.
REQ-009 code  output  CW  count of dec_bit=1 decisions in the last completed window.
REQ-010 code_valid  output  1  code available; held until accepted.
REQ-011 code_ready  input  1  consumer accepts code when high together with code_valid.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 overrun  output  1  sticky; a decision was dropped while a code awaited acceptance.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SETTLE, ACCUM, HOLD.
REQ-015 IDLE: en=1 -> SETTLE next edge; settle, sample and ones counters and overrun cleared on this transition; dec_stb ignored.
REQ-016 SETTLE: each dec_stb increments the settle counter, dec_bit ignored; on the NSETTLE-th strobe -> ACCUM.
REQ-017 ACCUM: each dec_stb increments the sample counter, and the ones counter when dec_bit=1.
REQ-018 ACCUM: on the NSAMP-th strobe, code SHALL load the ones total including that strobe's bit, code_valid SHALL rise on the same edge, state -> HOLD.
REQ-019 Latency: code_valid high in the cycle after the final-strobe cycle; exactly one clock edge.
REQ-020 Ones counter SHALL not wrap; all-ones window yields code = NSAMP.
REQ-021 HOLD: code and code_valid SHALL stay stable until a rising edge with code_valid=1 and code_ready=1.
REQ-022 HOLD handshake edge: code_valid -> 0; en=1 -> ACCUM with counters cleared and no re-settle; en=0 -> IDLE.
REQ-023 dec_stb during HOLD without handshake: decision dropped, overrun set to 1.
REQ-024 dec_stb on the handshake edge with en=1: counted as the first sample of the new window; overrun unchanged.
REQ-025 en=0 in SETTLE or ACCUM: -> IDLE next edge, partial counts discarded, no code_valid.
REQ-026 en=0 in HOLD: remain in HOLD until handshake, then IDLE.
REQ-027 code SHALL hold its last value in IDLE, SETTLE and ACCUM; it updates only per REQ-018.
REQ-028 busy SHALL be a registered decode of state (0 in IDLE, 1 otherwise).

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, force state IDLE, code=0, code_valid=0, busy=0, overrun=0, all counters 0.
REQ-030 Reset mid-conversion SHALL abort the window with no code_valid pulse.
REQ-031 After reset release, the first state change SHALL occur no earlier than the first rising clk edge.

Verification (bench uses NSAMP=8, NSETTLE=2, CW=4)
REQ-032 en=1, 2 settle strobes bit=1, then 8 strobes bits 1,0,1,1,0,0,1,0 -> code=4, code_valid high the cycle after the 8th strobe, busy=1.
REQ-033 8 accum strobes all bit=1 -> code=8 (no wrap); all bit=0 -> code=0.
REQ-034 HOLD with code_ready=0, one extra strobe -> overrun=1, code unchanged; then code_ready=1 -> code_valid=0, next window begins without settle.
REQ-035 Strobe bit=1 coincident with handshake edge, then 7 strobes bit=0 -> next code=1, overrun=0.
REQ-036 en dropped after 5 accum strobes -> IDLE next edge, busy=0, no code_valid; re-enable requires 2 settle strobes again.
REQ-037 reset pulsed mid-ACCUM between clock edges -> all outputs 0 before the next edge; no code_valid after release.
